// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and constants for the falling-block controller.
//   state_t    : controller sequencing states
//   piece_t    : active piece (type, footprint origin column/row)
//   KEY_*      : PS/2 make codes for the move keys
//   piece_mask : type -> 4x2 footprint, bit index = row*4 + col
package tetris_pkg;

    localparam int NUM_TYPES = 5;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [2:0] {
        IDLE, SPAWN, FALL, LOCK, CLEAR, GAMEOVER
    } state_t;

    typedef struct packed {
        logic [2:0] ptype;
        logic [3:0] x;
        logic [3:0] y;
    } piece_t;

    // bits [3:0] = top row cols 0..3, bits [7:4] = bottom row cols 0..3
    function automatic logic [7:0] piece_mask(input logic [2:0] t);
        case (t)
            3'd0:    piece_mask = 8'h33;  // 2x2 square
            3'd1:    piece_mask = 8'hFF;  // 4x2 block
            3'd2:    piece_mask = 8'h0F;  // 4x1 bar
            3'd3:    piece_mask = 8'h71;  // top c0, bottom c0-2
            3'd4:    piece_mask = 8'h72;  // top c1, bottom c0-2
            default: piece_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/tetris_game_ctrl_fit.sv
// piece_fit_check: combinational collision test for one candidate position.
//   board : occupancy, board[row][col]
//   ptype : piece type
//   x, y  : candidate origin, one bit wider than the board fields so that
//           0-1 wraps to 31 and reads as out of range
//   fit   : every footprint cell is on the board and unoccupied
module piece_fit_check
    import tetris_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ROWS = 12
) (
    input  logic [ROWS-1:0][COLS-1:0] board,
    input  logic [2:0]                ptype,
    input  logic [4:0]                x,
    input  logic [4:0]                y,
    output logic                      fit
);

    logic [7:0] mask;
    logic [5:0] cx;
    logic [5:0] cy;

    always_comb begin
        mask = piece_mask(ptype);
        fit  = 1'b1;
        cx   = '0;
        cy   = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                // 6-bit sums so x=31 plus offset cannot wrap back on-board
                cx = {1'b0, x} + 6'(c);
                cy = {1'b0, y} + 6'(r);
                if (mask[3'(r*4 + c)]) begin
                    if (cx >= 6'(COLS) || cy >= 6'(ROWS))
                        fit = 1'b0;
                    else if (board[cy[3:0]][cx[3:0]])
                        fit = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: sequencer for the falling-block game.
//   clk, reset      : clock, synchronous active-high reset
//   start           : leaves IDLE / GAMEOVER
//   tick            : gravity pulse
//   key_valid/code  : PS/2 move key (left 0x6B, right 0x74, down 0x72)
//   rd_row/rd_data  : combinational board row read for the renderer
//   piece_*         : active piece in cell units, piece_valid only in FALL
//   game_over       : high in GAMEOVER
//   lines           : saturating cleared-row count
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int COLS    = 16,
    parameter int ROWS    = 12,
    parameter int SPAWN_X = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic [3:0]  rd_row,
    output logic [15:0] rd_data,
    output logic [3:0]  piece_x,
    output logic [3:0]  piece_y,
    output logic [2:0]  piece_type,
    output logic        piece_valid,
    output logic        game_over,
    output logic [15:0] lines
);

    state_t                   state, state_n;
    logic [ROWS-1:0][COLS-1:0] board, board_n;
    logic [15:0]              lines_n;
    piece_t                   pc, pc_n;
    logic [2:0]               next_type, next_type_n;
    logic                     tick_pend, tick_pend_n;
    logic [3:0]               row, row_n;

    logic                     fit_l, fit_r, fit_d;
    logic [2:0]               dn_type;
    logic [4:0]               dn_x, dn_y;
    logic [7:0]               mask;
    logic                     drop;

    // The down checker doubles as the spawn checker while in SPAWN.
    assign dn_type = (state == SPAWN) ? next_type     : pc.ptype;
    assign dn_x    = (state == SPAWN) ? 5'(SPAWN_X)   : {1'b0, pc.x};
    assign dn_y    = (state == SPAWN) ? 5'd0          : {1'b0, pc.y} + 5'd1;

    piece_fit_check #(.COLS(COLS), .ROWS(ROWS)) u_fit_l (
        .board(board), .ptype(pc.ptype),
        .x({1'b0, pc.x} - 5'd1), .y({1'b0, pc.y}), .fit(fit_l)
    );
    piece_fit_check #(.COLS(COLS), .ROWS(ROWS)) u_fit_r (
        .board(board), .ptype(pc.ptype),
        .x({1'b0, pc.x} + 5'd1), .y({1'b0, pc.y}), .fit(fit_r)
    );
    piece_fit_check #(.COLS(COLS), .ROWS(ROWS)) u_fit_d (
        .board(board), .ptype(dn_type), .x(dn_x), .y(dn_y), .fit(fit_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            board     <= '0;
            lines     <= '0;
            pc        <= '0;
            next_type <= '0;
            tick_pend <= 1'b0;
            row       <= '0;
        end else begin
            state     <= state_n;
            board     <= board_n;
            lines     <= lines_n;
            pc        <= pc_n;
            next_type <= next_type_n;
            tick_pend <= tick_pend_n;
            row       <= row_n;
        end
    end

    always_comb begin
        state_n     = state;
        board_n     = board;
        lines_n     = lines;
        pc_n        = pc;
        next_type_n = next_type;
        tick_pend_n = tick_pend;
        row_n       = row;
        drop        = 1'b0;
        mask        = piece_mask(pc.ptype);
        case (state)
            IDLE: begin
                if (start) begin
                    board_n = '0;
                    lines_n = '0;
                    state_n = SPAWN;
                end
            end
            SPAWN: begin
                pc_n.ptype  = next_type;
                pc_n.x      = 4'(SPAWN_X);
                pc_n.y      = 4'd0;
                next_type_n = (next_type == 3'(NUM_TYPES - 1)) ? 3'd0 : next_type + 3'd1;
                state_n     = fit_d ? FALL : GAMEOVER;
            end
            FALL: begin
                if (key_valid) begin
                    // a coincident tick is deferred one cycle behind the key
                    tick_pend_n = tick_pend | tick;
                    case (key_code)
                        KEY_LEFT:  if (fit_l) pc_n.x = pc.x - 4'd1;
                        KEY_RIGHT: if (fit_r) pc_n.x = pc.x + 4'd1;
                        KEY_DOWN:  drop = 1'b1;
                        default:   ;
                    endcase
                end else if (tick || tick_pend) begin
                    drop        = 1'b1;
                    tick_pend_n = 1'b0;
                end
                if (drop) begin
                    if (fit_d) begin
                        pc_n.y = pc.y + 4'd1;
                    end else begin
                        state_n     = LOCK;
                        tick_pend_n = 1'b0;
                    end
                end
            end
            LOCK: begin
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 4; c++)
                        if (mask[3'(r*4 + c)])
                            board_n[pc.y + 4'(r)][pc.x + 4'(c)] = 1'b1;
                row_n   = 4'(ROWS - 1);
                state_n = CLEAR;
            end
            CLEAR: begin
                if (&board[row]) begin
                    // collapse rows above; row is rescanned next cycle
                    for (int r = ROWS - 1; r > 0; r--)
                        if (4'(r) <= row)
                            board_n[r] = board[r-1];
                    board_n[0] = '0;
                    lines_n    = (&lines) ? lines : lines + 16'd1;
                end else if (row == 4'd0) begin
                    state_n = SPAWN;
                end else begin
                    row_n = row - 4'd1;
                end
            end
            GAMEOVER: begin
                if (start) begin
                    board_n     = '0;
                    lines_n     = '0;
                    next_type_n = '0;
                    state_n     = SPAWN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_data     = (rd_row < 4'(ROWS)) ? board[rd_row] : '0;
    assign piece_x     = pc.x;
    assign piece_y     = pc.y;
    assign piece_type  = pc.ptype;
    assign piece_valid = (state == FALL);
    assign game_over   = (state == GAMEOVER);

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb_tetris_game_ctrl: directed game scenarios against a behavioural model.
module tb_tetris_game_ctrl;

    localparam int ROWS = 12;
    localparam int COLS = 16;
    localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_BUSY = 3, P_OVER = 4;

    logic        clk = 1'b0;
    logic        reset, start, tick, key_valid;
    logic [7:0]  key_code;
    logic [3:0]  rd_row;
    logic [15:0] rd_data, lines;
    logic [3:0]  piece_x, piece_y;
    logic [2:0]  piece_type;
    logic        piece_valid, game_over;

    always #5 clk = ~clk;

    tetris_game_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .key_valid(key_valid), .key_code(key_code), .rd_row(rd_row),
        .rd_data(rd_data), .piece_x(piece_x), .piece_y(piece_y),
        .piece_type(piece_type), .piece_valid(piece_valid),
        .game_over(game_over), .lines(lines)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ph = P_IDLE, m_lines = 0, m_x = 0, m_y = 0, m_t = 0, m_nt = 0, m_busy = 0;
    bit m_pend = 0;
    bit mb[ROWS][COLS];

    function automatic bit m_cell(int t, int c, int r);
        case (t)
            0: return c < 2;
            1: return 1'b1;
            2: return r == 0;
            3: return (r == 1) ? (c < 3) : (c == 0);
            4: return (r == 1) ? (c < 3) : (c == 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_fit(int t, int x, int y);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                if (m_cell(t, c, r)) begin
                    if (x + c < 0 || x + c >= COLS || y + r < 0 || y + r >= ROWS) return 1'b0;
                    if (mb[y+r][x+c]) return 1'b0;
                end
        return 1'b1;
    endfunction

    function automatic int m_row(int r);
        int v = 0;
        if (r >= ROWS) return 0;
        for (int c = 0; c < COLS; c++) if (mb[r][c]) v |= (1 << c);
        return v;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mb[r][c] = 1'b0;
    endtask

    // paint, then compact surviving rows to the bottom in one step
    task automatic m_land();
        int k = 0, w = ROWS - 1;
        bit full;
        bit nb[ROWS][COLS];
        nb = '{default: '0};
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                if (m_cell(m_t, c, r)) mb[m_y+r][m_x+c] = 1'b1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) full &= mb[r][c];
            if (full) k++;
            else begin
                for (int c = 0; c < COLS; c++) nb[w][c] = mb[r][c];
                w--;
            end
        end
        mb      = nb;
        m_lines = (m_lines + k > 65535) ? 65535 : m_lines + k;
        m_busy  = 1 + k + ROWS;  // lock cycle, k shifts, full rescan
        m_pend  = 1'b0;
        m_ph    = P_BUSY;
    endtask

    task automatic m_step();
        bit g = 1'b0;
        if (reset) begin
            m_ph = P_IDLE; m_clear(); m_lines = 0;
            m_x = 0; m_y = 0; m_t = 0; m_nt = 0; m_pend = 1'b0;
            return;
        end
        case (m_ph)
            P_IDLE: if (start) begin m_clear(); m_lines = 0; m_ph = P_SPAWN; end
            P_SPAWN: begin
                m_t = m_nt; m_x = 6; m_y = 0; m_nt = (m_nt + 1) % 5;
                m_ph = m_fit(m_t, m_x, m_y) ? P_FALL : P_OVER;
            end
            P_FALL: begin
                if (key_valid) begin
                    if (tick) m_pend = 1'b1;
                    if (key_code == 8'h6B && m_fit(m_t, m_x - 1, m_y)) m_x--;
                    else if (key_code == 8'h74 && m_fit(m_t, m_x + 1, m_y)) m_x++;
                    else if (key_code == 8'h72) g = 1'b1;
                end else if (tick || m_pend) begin
                    g = 1'b1; m_pend = 1'b0;
                end
                if (g) begin
                    if (m_fit(m_t, m_x, m_y + 1)) m_y++;
                    else m_land();
                end
            end
            P_BUSY: begin m_busy--; if (m_busy == 0) m_ph = P_SPAWN; end
            P_OVER: if (start) begin m_clear(); m_lines = 0; m_nt = 0; m_ph = P_SPAWN; end
            default: m_ph = P_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    // per-cycle compare; rd_row sweeps all 16 codes
    initial begin
        int rr = 0;
        forever begin
            @(negedge clk);
            rd_row = 4'(rr);
            #1;
            chk("valid", int'(piece_valid), int'(m_ph == P_FALL));
            chk("game_over", int'(game_over), int'(m_ph == P_OVER));
            if (m_ph == P_FALL) begin
                chk("piece_x", int'(piece_x), m_x);
                chk("piece_y", int'(piece_y), m_y);
                chk("piece_type", int'(piece_type), m_t);
            end
            if (m_ph != P_BUSY) begin
                chk("lines", int'(lines), m_lines);
                chk($sformatf("rd_data[%0d]", rr), int'(rd_data), m_row(rr));
            end
            rr = (rr + 1) % 16;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input bit s, input bit t, input bit kv, input logic [7:0] kc);
        @(negedge clk);
        start = s; tick = t; key_valid = kv; key_code = kc;
        @(negedge clk);
        start = 1'b0; tick = 1'b0; key_valid = 1'b0;
        #2;
    endtask

    task automatic rdchk(input int r, input int exp);
        rd_row = 4'(r);
        #1;
        chk($sformatf("lit_row%0d", r), int'(rd_data), exp);
    endtask

    // count low-valid samples (one already seen) until next FALL or GAMEOVER
    task automatic wait_fall(output int n);
        bit done = 1'b0;
        n = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk); #2;
            if (piece_valid || game_over) done = 1'b1;
            else n++;
        end
        if (!done) chk("wait_fall_timeout", 0, 1);
    endtask

    task automatic drop(input bit use_key, output int n);
        int k = 0;
        while (piece_valid && k < 20) begin
            if (use_key) pulse(1'b0, 1'b0, 1'b1, 8'h72);
            else         pulse(1'b0, 1'b1, 1'b0, 8'h00);
            k++;
        end
        if (k >= 20) chk("drop_timeout", 0, 1);
        wait_fall(n);
    endtask

    task automatic moves(input int cnt, input logic [7:0] kc);
        repeat (cnt) pulse(1'b0, 1'b0, 1'b1, kc);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; tick = 1'b0; key_valid = 1'b0;
        key_code = 8'h00; rd_row = 4'd0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_valid", int'(piece_valid), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_lines", int'(lines), 0);
        chk("rst_pos", int'({piece_type, piece_x, piece_y}), 0);
        reset = 1'b0;

        pulse(1'b0, 1'b1, 1'b0, 8'h00);          // tick in IDLE: dropped
        pulse(1'b0, 1'b0, 1'b1, 8'h6B);          // key in IDLE: dropped
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        chk("spawn_valid_low", int'(piece_valid), 0);
        @(negedge clk); #2;
        chk("first_valid", int'(piece_valid), 1);
        chk("first_xyt", int'({piece_type, piece_x, piece_y}), {3'd0, 4'd6, 4'd0});

        moves(7, 8'h6B);  chk("left_wall", int'(piece_x), 0);
        moves(16, 8'h74); chk("right_wall", int'(piece_x), 14);
        moves(8, 8'h6B);  chk("back_to_6", int'(piece_x), 6);

        repeat (10) pulse(1'b0, 1'b1, 1'b0, 8'h00);
        chk("y_bottom", int'(piece_y), 10);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        chk("lock_valid", int'(piece_valid), 0);
        wait_fall(n);
        chk("noclear_cycles", n, 14);
        rdchk(11, 16'h00C0);
        rdchk(10, 16'h00C0);
        chk("type1_next", int'(piece_type), 1);

        // fill row 11 around the square: type1@8, bar@12, type3@0, type4@3
        moves(2, 8'h74); drop(1'b0, n);
        pulse(1'b0, 1'b0, 1'b1, 8'h1C);          // unmapped code ignored
        moves(6, 8'h74); drop(1'b1, n);
        moves(6, 8'h6B); drop(1'b1, n);
        moves(3, 8'h6B);
        chk("type4_x", int'({piece_type, piece_x}), {3'd4, 4'd3});
        drop(1'b0, n);
        chk("clear_cycles", n, 15);
        chk("lines_one", int'(lines), 1);
        rdchk(11, 16'h0FD1);
        rdchk(10, 16'h0000);
        chk("type_wrap", int'(piece_type), 0);

        // tick coincident with left key
        repeat (3) pulse(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pre_y3", int'(piece_y), 3);
        pulse(1'b0, 1'b1, 1'b1, 8'h6B);
        chk("simul_c1", int'({piece_x, piece_y}), {4'd5, 4'd3});
        @(negedge clk); #2;
        chk("simul_c2", int'(piece_y), 4);
        drop(1'b0, n);

        // stack at the spawn column until spawn collides
        for (int i = 0; i < 15 && !game_over; i++) drop(1'b0, n);
        chk("game_over", int'(game_over), 1);
        pulse(1'b0, 1'b1, 1'b1, 8'h72);          // ignored in GAMEOVER
        repeat (20) @(negedge clk);
        #2;
        chk("over_lines_hold", int'(lines), 1);

        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk); #2;
        chk("restart_valid", int'(piece_valid), 1);
        chk("restart_type", int'(piece_type), 0);
        chk("restart_lines", int'(lines), 0);
        for (int r = 0; r < 16; r++) rdchk(r, 0);

        // reset while scanning CLEAR
        drop(1'b0, n);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("midclr_valid", int'(piece_valid), 0);
        rdchk(11, 0);
        rdchk(10, 0);
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk); #2;
        chk("post_rst_type", int'(piece_type), 0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
